adpll_loop_filter: RTL
======================

# adpll_loop_filter

Digital proportional-integral loop filter for the ADPLL. It consumes the 1-bit bang-bang phase-detector decision and produces the 9-bit frequency control word (`k_val`) for the phase-accumulator DCO. It closes the loop between the PD and the oscillator. It also provides an update strobe and a lock indicator for the LEDs and debug headers.

## Interface

- `OUT_WIDTH`, 9, control word width; matches the DCO `k_val_i`.
- `FRAC_BITS`, 6, fractional bits held in the integrator below the output LSB.
- `KP`, 4, proportional step in output LSBs.
- `KI`, 1, integral step in integrator LSBs (1/2^FRAC_BITS output LSB).
- `CENTER`, 256, reset and initial control word.
- `LOCK_COUNT`, 16, consecutive alternating decisions required to assert lock.

- `fpga_clk_i`  in  1  system clock (160 MHz); all state on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  synchronous enable; low freezes the filter.
- `ref_i`  in  1  reference clock (5 MHz); asynchronous to `fpga_clk_i`.
- `pd_i`  in  1  bang-bang decision; asynchronous. 1 means the generated clock lags, so frequency must increase.
- `k_val_o`  out  OUT_WIDTH  registered frequency control word.
- `update_o`  out  1  one-cycle pulse in the cycle `k_val_o` is refreshed.
- `lock_o`  out  1  registered lock flag.

## Operation

- **Synchronisers.** `ref_i` and `pd_i` each pass through a 2-flop synchroniser. A third flop on synced ref gives edge detection. Synchronisers run regardless of `enable_i`.
- **Update event.** The update event is a detected falling edge of synced ref, at mid-period of ref, when the PD output is stable. The decision `d` is the synced pd value in that cycle.
- **Integrator.** The integrator is unsigned, OUT_WIDTH+FRAC_BITS bits (15 at defaults).
  - Reset value: CENTER << FRAC_BITS.
  - On an update, it adds KI if d=1 and subtracts KI if d=0.
  - It saturates at 0 and 2^(OUT_WIDTH+FRAC_BITS)-1 and never wraps.
- **Output.** On an update, `k_val_o` = clamp((int_next >> FRAC_BITS) ± KP, 0, 2^OUT_WIDTH-1).
  - int_next is the post-update integrator value.
  - The sign is + for d=1 and − for d=0.
  - Compute in at least OUT_WIDTH+2 bits signed so the clamp is exact.
- **Lock detector.** State is `prev_d`, a `prev_valid` flag, and a saturating counter `alt_cnt`.
  - First update after reset or after enable rises: only load `prev_d`, set `prev_valid`, and leave `alt_cnt` unchanged.
  - Later updates with d ≠ prev_d: `alt_cnt` increments, saturating at LOCK_COUNT.
  - Later updates with d = prev_d: `alt_cnt` clears to 0.
  - `lock_o` = (`alt_cnt` == LOCK_COUNT), registered.
- **enable_i low.**
  - Update events are ignored: no integrator change, no `k_val_o` change, no `update_o`.
  - `alt_cnt`, `prev_valid` and `lock_o` clear.
  - Edge-detect flops keep tracking, so raising enable never produces a spurious edge.
- **Reset values.**
  - `k_val_o` = CENTER, `update_o` = 0, `lock_o` = 0.
  - Integrator = CENTER<<FRAC_BITS.
  - `alt_cnt` = 0, `prev_valid` = 0, `prev_d` = 0.
  - All synchroniser and edge flops = 0.

## Timing

- **Latency.** A falling edge on `ref_i` produces the `k_val_o` change and `update_o` pulse on the 4th `fpga_clk_i` rising edge after it, +1 cycle synchroniser uncertainty. The edges are: sync1, sync2, edge detect, output register.
- **Decision sampling.** `pd_i` must be stable for ≥3 clk cycles before the ref falling edge. It is sampled through an identical-depth synchroniser, so it is aligned with ref.
- **Update rate.** Exactly one update per ref period. `update_o` is high for exactly 1 cycle.
- **lock_o** changes in the same cycle as the corresponding `update_o`. It clears 1 cycle after `enable_i` is sampled low.
- **reset_i** takes effect immediately, without a clock edge, including mid-update. The first update can occur only after a full ref falling edge is seen post-reset.
- **Simultaneous events.** An update event in the same cycle `enable_i` falls is ignored. An update in the cycle `enable_i` rises is processed as the first (unpaired) decision.

## Test plan

- **Reset.** Assert `reset_i` mid-run with no clock running → `k_val_o` = 256, `lock_o` = 0 and `update_o` = 0 immediately. After release, no `update_o` occurs until a ref falling edge.
- **Proportional and integral steps.** Hold pd=1 with 5 MHz ref.
  - 1st update → `k_val_o` = 260, integrator 16385.
  - After 64 updates → integrator 16448 → `k_val_o` = 261.
  - `update_o` pulses once per ref period, 4±1 clk after each ref fall.
- **Lock.** Alternate pd every ref period from reset.
  - `k_val_o` toggles 260/252.
  - `lock_o` rises on the 17th update.
  - Two consecutive identical decisions then drop `lock_o` on that update.
- **Saturation.** Build with CENTER=511 and hold pd=1 for 100 updates → `k_val_o` stays 511, integrator stays 32767. Then one pd=0 update → `k_val_o` = 507.
- **Enable.** Drop `enable_i` while locked → `lock_o` falls next cycle. Across 10 ref periods: no `update_o`, `k_val_o` unchanged. Re-enable → next update applies normally and does not count toward lock.
- **Lower clamp.** Build with CENTER=2 and hold pd=0 → `k_val_o` = 0 from the 1st update, integrator floors at 0 with no wrap. Then pd=1 → `k_val_o` rises from 0 by KP plus the integer part.

Source files
------------

// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter: proportional-integral loop filter for the ADPLL.
// Ports: fpga_clk_i, reset_i (async, active-high), enable_i, ref_i, pd_i,
//   k_val_o (DCO control word), update_o (refresh strobe), lock_o.
module adpll_loop_filter #(
  parameter int OUT_WIDTH  = 9,
  parameter int FRAC_BITS  = 6,
  parameter int KP         = 4,
  parameter int KI         = 1,
  parameter int CENTER     = 256,
  parameter int LOCK_COUNT = 16
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 ref_i,
  input  logic                 pd_i,
  output logic [OUT_WIDTH-1:0] k_val_o,
  output logic                 update_o,
  output logic                 lock_o
);

  localparam int IW = OUT_WIDTH + FRAC_BITS;
  localparam int SW = IW + 2;
  localparam int OW = OUT_WIDTH + 3;
  localparam int CW = $clog2(LOCK_COUNT + 1);

  localparam logic [IW-1:0] INT_MAX = {IW{1'b1}};
  localparam logic [IW-1:0] INT_RST = IW'(CENTER * (2 ** FRAC_BITS));
  localparam logic [OUT_WIDTH-1:0] K_RST = OUT_WIDTH'(CENTER);
  localparam logic [CW-1:0] ALT_MAX = CW'(LOCK_COUNT);

  logic ref_s1_q, ref_s2_q, ref_s3_q;
  logic pd_s1_q, pd_s2_q;
  logic ev_q, d_q;

  logic [IW-1:0]        integ_q, integ_d;
  logic [OUT_WIDTH-1:0] k_q, k_d;
  logic                 update_q;
  logic                 lock_q;
  logic                 prev_d_q;
  logic                 prev_valid_q;
  logic [CW-1:0]        alt_cnt_q, alt_cnt_d;

  logic signed [SW-1:0] int_sum;
  logic signed [OW-1:0] prop;

  always_comb begin
    int_sum = $signed({2'b00, integ_q});
    if (d_q) int_sum = int_sum + $signed(SW'(KI));
    else     int_sum = int_sum - $signed(SW'(KI));

    integ_d = int_sum[IW-1:0];
    if (int_sum < 0)
      integ_d = '0;
    else if (int_sum > $signed({2'b00, INT_MAX}))
      integ_d = INT_MAX;

    // Proportional kick is applied around the post-update integer part.
    prop = $signed({3'b000, integ_d[IW-1:FRAC_BITS]});
    if (d_q) prop = prop + $signed(OW'(KP));
    else     prop = prop - $signed(OW'(KP));

    k_d = prop[OUT_WIDTH-1:0];
    if (prop < 0)
      k_d = '0;
    else if (prop > $signed({3'b000, {OUT_WIDTH{1'b1}}}))
      k_d = {OUT_WIDTH{1'b1}};

    alt_cnt_d = alt_cnt_q;
    if (prev_valid_q) begin
      if (d_q != prev_d_q) begin
        if (alt_cnt_q != ALT_MAX) alt_cnt_d = alt_cnt_q + 1'b1;
      end else begin
        alt_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      ref_s1_q     <= 1'b0;
      ref_s2_q     <= 1'b0;
      ref_s3_q     <= 1'b0;
      pd_s1_q      <= 1'b0;
      pd_s2_q      <= 1'b0;
      ev_q         <= 1'b0;
      d_q          <= 1'b0;
      integ_q      <= INT_RST;
      k_q          <= K_RST;
      update_q     <= 1'b0;
      lock_q       <= 1'b0;
      prev_d_q     <= 1'b0;
      prev_valid_q <= 1'b0;
      alt_cnt_q    <= '0;
    end else begin
      ref_s1_q <= ref_i;
      ref_s2_q <= ref_s1_q;
      ref_s3_q <= ref_s2_q;
      pd_s1_q  <= pd_i;
      pd_s2_q  <= pd_s1_q;
      // Falling edge of synced ref: mid-period, PD output settled.
      ev_q     <= ref_s3_q & ~ref_s2_q;
      d_q      <= pd_s2_q;
      update_q <= 1'b0;
      if (!enable_i) begin
        alt_cnt_q    <= '0;
        prev_valid_q <= 1'b0;
        lock_q       <= 1'b0;
      end else if (ev_q) begin
        integ_q      <= integ_d;
        k_q          <= k_d;
        update_q     <= 1'b1;
        prev_d_q     <= d_q;
        prev_valid_q <= 1'b1;
        alt_cnt_q    <= alt_cnt_d;
        lock_q       <= (alt_cnt_d == ALT_MAX);
      end
    end
  end

  assign k_val_o  = k_q;
  assign update_o = update_q;
  assign lock_o   = lock_q;

endmodule
